// File: rtl/counter_sequencer.sv
// Prescaled up-counter sequencer: one-shot or auto-reload, with pause, abort, busy and done pulse.
// Define COUNTER_SEQUENCER_PERIOD_CNT_EN to add the saturating period_cnt output.
module counter_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             mode_reload,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
  output logic [7:0]       period_cnt,
`endif
  output logic [1:0]       state
);
  // state | meaning
  // IDLE  | waiting for start; Q holds its last value
  // RUN   | counting on prescaled ticks
  // PAUSE | prescaler and Q frozen while pause is high
  // DONE  | one-shot finished; lasts one cycle, then IDLE
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_LOAD = PW'(PRESCALE - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             accept, kill, active, tick, at_term;
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
  logic [7:0]       pcnt_q, pcnt_d;
`endif

  assign accept  = (state_q == S_IDLE) && start;
  assign kill    = (state_q != S_IDLE) && abort;
  // PAUSE with pause released behaves as RUN on that edge, so a pause costs exactly its length.
  assign active  = ((state_q == S_RUN) || (state_q == S_PAUSE)) && !abort && !pause;
  assign tick    = active && (psc_q == '0);
  assign at_term = (q_q == term_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      term_q  <= '0;
      psc_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
      pcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      term_q  <= term_d;
      psc_q   <= psc_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
      pcnt_q  <= pcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN, S_PAUSE: begin
        if (abort)                           state_d = S_IDLE;
        else if (pause)                      state_d = S_PAUSE;
        else if (tick && at_term && !mode_q) state_d = S_DONE;
        else                                 state_d = S_RUN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    q_d    = q_q;
    term_d = term_q;
    psc_d  = psc_q;
    mode_d = mode_q;
    done_d = 1'b0;
    if (accept) begin
      term_d = terminal;
      mode_d = mode_reload;
      q_d    = '0;
      psc_d  = PSC_LOAD;
    end else if (kill) begin
      q_d    = '0;
      psc_d  = '0;
    end else if (active) begin
      psc_d = tick ? PSC_LOAD : (psc_q - PW'(1));
      if (tick) begin
        if (at_term) begin
          done_d = 1'b1;
          if (mode_q) q_d = '0;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end
    end
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
  always_comb begin
    pcnt_d = pcnt_q;
    if (accept || kill)                 pcnt_d = '0;
    else if (done_d && pcnt_q != 8'hFF) pcnt_d = pcnt_q + 8'd1;
  end

  assign period_cnt = pcnt_q;
`endif

  assign Q     = q_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: two instances (PRESCALE=1 and 2) share one stimulus stream.
module tb_counter_sequencer;
  logic       clk = 1'b0;
  logic       reset_n, start, pause, abort, mode_reload;
  logic [3:0] terminal;
  logic [3:0] q1, q2;
  logic       busy1, busy2, done1, done2;
  logic [1:0] st1, st2;
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
  logic [7:0] pc1, pc2;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(4), .PRESCALE(1)) u_p1 (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .abort(abort),
    .mode_reload(mode_reload), .terminal(terminal), .Q(q1), .busy(busy1), .done(done1),
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
    .period_cnt(pc1),
`endif
    .state(st1)
  );

  counter_sequencer #(.WIDTH(4), .PRESCALE(2)) u_p2 (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .abort(abort),
    .mode_reload(mode_reload), .terminal(terminal), .Q(q2), .busy(busy2), .done(done2),
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
    .period_cnt(pc2),
`endif
    .state(st2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start pulse on one edge (E0); returns just after E0.
  task automatic go(input logic [3:0] t, input logic m);
    terminal    = t;
    mode_reload = m;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic clear_all();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    mode_reload = 1'b0; terminal = 4'd0;
    #20;
    check("rst_q",     q1,    0);
    check("rst_busy",  busy1, 0);
    check("rst_done",  done1, 0);
    check("rst_state", st1,   0);
    #3 reset_n = 1'b1;
    step();

    // one-shot, terminal 5, PRESCALE 1
    go(4'd5, 1'b0);
    check("os_e0_q", q1, 0);
    check("os_e0_state", st1, 1);
    check("os_e0_busy", busy1, 1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("os_q", q1, i);
      check("os_busy", busy1, 1);
      check("os_nodone", done1, 0);
    end
    start = 1'b1;
    step();
    check("os_e6_done", done1, 1);
    check("os_e6_state", st1, 3);
    check("os_e6_q", q1, 5);
    check("os_e6_busy", busy1, 0);
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
    check("os_pcnt", pc1, 1);
`endif
    step();
    start = 1'b0;
    check("os_e7_state_start_ign", st1, 0);
    check("os_e7_q", q1, 5);
    check("os_e7_done", done1, 0);
    clear_all();

    // auto-reload, terminal 3, PRESCALE 2
    go(4'd3, 1'b1);
    check("rl_e0_q", q2, 0);
    for (int i = 1; i <= 24; i++) begin
      step();
      check("rl_q", q2, (i % 8) / 2);
      check("rl_done", done2, (i % 8) == 0);
      check("rl_busy", busy2, 1);
    end
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
    check("rl_pcnt3", pc2, 3);
`endif
    clear_all();
    check("rl_abort_state", st2, 0);
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
    check("rl_pcnt_clr", pc2, 0);
`endif

    // pause at Q=4 for four edges, terminal 9
    go(4'd9, 1'b0);
    repeat (4) step();
    check("ps_e4_q", q1, 4);
    pause = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      step();
      check("ps_hold_q", q1, 4);
      check("ps_hold_state", st1, 2);
      check("ps_hold_busy", busy1, 1);
    end
    pause = 1'b0;
    for (int e = 9; e <= 13; e++) begin
      step();
      check("ps_res_q", q1, e - 4);
      check("ps_res_done", done1, 0);
    end
    step();
    check("ps_e14_done", done1, 1);
    check("ps_e14_q", q1, 9);
    clear_all();

    // start ignored in RUN, then abort at Q=6
    go(4'd9, 1'b0);
    repeat (2) step();
    start = 1'b1; terminal = 4'd2;
    step();
    start = 1'b0;
    check("ab_e3_q", q1, 3);
    check("ab_e3_state", st1, 1);
    check("ab_e3_done", done1, 0);
    repeat (3) step();
    check("ab_e6_q", q1, 6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_state", st1, 0);
    check("ab_q", q1, 0);
    check("ab_done", done1, 0);
    check("ab_busy", busy1, 0);
    step();
    check("ab_after_done", done1, 0);
    check("ab_after_state", st1, 0);
    clear_all();

    // terminal 0 one-shot
    go(4'd0, 1'b0);
    check("t0_e0_state", st1, 1);
    step();
    check("t0_done", done1, 1);
    check("t0_state", st1, 3);
    check("t0_q", q1, 0);
    clear_all();

    // terminal 0 reload: done every tick, Q stays 0
    go(4'd0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("t0r_done", done1, 1);
      check("t0r_q", q1, 0);
    end
    clear_all();

    // terminal 15 reload
    go(4'd15, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      step();
      check("t15_q", q1, i);
      check("t15_nodone", done1, 0);
    end
    step();
    check("t15_wrap_q", q1, 0);
    check("t15_wrap_done", done1, 1);
    check("t15_wrap_state", st1, 1);
    clear_all();

    // abort coinciding with the terminal tick
    go(4'd3, 1'b0);
    repeat (3) step();
    check("at_e3_q", q1, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("at_done", done1, 0);
    check("at_state", st1, 0);
    check("at_q", q1, 0);
    clear_all();

    // asynchronous reset mid-run at Q=3
    go(4'd9, 1'b0);
    repeat (3) step();
    check("ar_pre_q", q1, 3);
    reset_n = 1'b0;
    #2;
    check("ar_q", q1, 0);
    check("ar_busy", busy1, 0);
    check("ar_done", done1, 0);
    check("ar_state", st1, 0);
    #98;
    reset_n = 1'b1;
    step();
    check("ar_post_q", q1, 0);
    check("ar_post_state", st1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
